// File: rtl/periph_bus_master.sv
// Bus initiator for the 0x4000_0000 peripheral region: queued host commands, single-cycle bus
// accesses, read responses over valid/ready, sticky IRQ flag. IRQ_AUTO_ACK_EN adds timer auto-ack.
module periph_bus_master #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] TCON_ADDR = 32'h4000_0008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  input  logic        IRQ,
  output logic        irq_pending,
  input  logic        irq_clear
);

  // state    | meaning
  // IDLE     | waiting for a queued command (or an IRQ edge to acknowledge)
  // ISSUE    | bus strobe active for exactly one cycle
  // RESP     | read data held on rsp_* until the host takes it
  // ACK_RD   | reading the timer control register
  // ACK_WAIT | one quiet cycle between the ack read and write
  // ACK_WR   | writing back control value with status bit 2 cleared

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("periph_bus_master: DEPTH must be a power of two and at least 2");
  end
  if (TCON_ADDR[1:0] != 2'b00) begin : g_bad_tcon
    $error("periph_bus_master: TCON_ADDR must be word aligned");
  end

`ifdef IRQ_AUTO_ACK_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RESP, S_ACK_RD, S_ACK_WAIT, S_ACK_WR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
`endif

  state_t state_q, state_d;

  logic [31:0]   fifo_addr_q  [DEPTH];
  logic [31:0]   fifo_wdata_q [DEPTH];
  logic          fifo_write_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, fifo_empty;

  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic irq_q, irq_prev_q, irq_rise;
  logic irq_pending_q, irq_pending_d;

`ifdef IRQ_AUTO_ACK_EN
  logic [31:0] ack_data_q, ack_data_d;
  logic        ack_req_q, ack_req_d;
  logic        ack_take;
`endif

  assign cmd_ready  = (count_q != CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      fifo_write_q[wr_ptr_q] <= cmd_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // IRQ is synchronised once; the edge is taken between the first and second flop.
  assign irq_rise      = irq_q && !irq_prev_q;
  assign irq_pending_d = irq_rise || (irq_pending_q && !irq_clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q         <= 1'b0;
      irq_prev_q    <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_q         <= IRQ;
      irq_prev_q    <= irq_q;
      irq_pending_q <= irq_pending_d;
    end
  end

`ifdef IRQ_AUTO_ACK_EN
  assign ack_take = (state_q == S_IDLE) && (ack_req_q || irq_rise);
`endif

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    write_data_d = '0;
    address_d    = address_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef IRQ_AUTO_ACK_EN
    ack_data_d   = ack_data_q;
    ack_req_d    = ack_req_q || irq_rise;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef IRQ_AUTO_ACK_EN
        if (ack_take) begin
          ack_req_d  = 1'b0;
          address_d  = TCON_ADDR;
          mem_read_d = 1'b1;
          state_d    = S_ACK_RD;
        end else
`endif
        if (!fifo_empty) begin
          pop       = 1'b1;
          address_d = fifo_addr_q[rd_ptr_q];
          if (fifo_write_q[rd_ptr_q]) begin
            mem_write_d  = 1'b1;
            write_data_d = fifo_wdata_q[rd_ptr_q];
          end else begin
            mem_read_d = 1'b1;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_read_q) begin
          rsp_rdata_d = ReadData;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef IRQ_AUTO_ACK_EN
      S_ACK_RD: begin
        ack_data_d = ReadData;
        state_d    = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        // Bit 2 is the interrupt status; enable bits are written back unchanged.
        mem_write_d  = 1'b1;
        write_data_d = ack_data_q & 32'hFFFF_FFFB;
        state_d      = S_ACK_WR;
      end
      S_ACK_WR: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

`ifdef IRQ_AUTO_ACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_data_q <= '0;
      ack_req_q  <= 1'b0;
    end else begin
      ack_data_q <= ack_data_d;
      ack_req_q  <= ack_req_d;
    end
  end
`endif

  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign Address     = address_q;
  assign WriteData   = write_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master (default build): writes, reads, FIFO backpressure,
// IRQ flag behaviour and reset during an access.
module tb_periph_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic        IRQ, irq_pending, irq_clear;

  int tests  = 0;
  int failed = 0;

  logic [31:0] systick = '0;
  logic [7:0]  led = '0;
  logic [31:0] stick;

  periph_bus_master #(.DEPTH(4), .TCON_ADDR(32'h4000_0008)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData),
    .IRQ(IRQ), .irq_pending(irq_pending), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  // Minimal peripheral: free-running systick at 0x40000014, LED register at 0x4000000C,
  // everything else reads back as address ^ 0xA5A50000.
  always_ff @(posedge clk) begin
    systick <= systick + 32'd1;
    if (MemWrite && Address == 32'h4000_000C) led <= WriteData[7:0];
  end
  assign ReadData = (Address == 32'h4000_0014) ? systick : (Address ^ 32'hA5A5_0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; IRQ = 1'b0; irq_clear = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_memread",  32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_address",  Address, 32'd0);
    chk("rst_wdata",    WriteData, 32'd0);
    chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata",    rsp_rdata, 32'd0);
    chk("rst_irqpend",  32'(irq_pending), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmdready", 32'(cmd_ready), 32'd1);

    // Single write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_000C; cmd_wdata = 32'h0000_00A5;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wr_idle_nostrobe", 32'(MemWrite), 32'd0);
    @(negedge clk);
    chk("wr_strobe",   32'(MemWrite), 32'd1);
    chk("wr_noread",   32'(MemRead), 32'd0);
    chk("wr_address",  Address, 32'h4000_000C);
    chk("wr_wdata",    WriteData, 32'h0000_00A5);
    @(negedge clk);
    chk("wr_strobe_off", 32'(MemWrite), 32'd0);
    chk("wr_wdata_zero", WriteData, 32'd0);
    chk("wr_addr_hold",  Address, 32'h4000_000C);
    chk("wr_norsp",      32'(rsp_valid), 32'd0);
    chk("wr_led",        32'(led), 32'h0000_00A5);

    // Read systick with host ready
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0014; cmd_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rd_c1_noread", 32'(MemRead), 32'd0);
    chk("rd_c1_norsp",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_c2_read",   32'(MemRead), 32'd1);
    chk("rd_c2_addr",   Address, 32'h4000_0014);
    chk("rd_c2_nowd",   WriteData, 32'd0);
    chk("rd_c2_norsp",  32'(rsp_valid), 32'd0);
    stick = systick;
    @(negedge clk);
    chk("rd_c3_rspvalid", 32'(rsp_valid), 32'd1);
    chk("rd_c3_rdata",    rsp_rdata, stick);
    chk("rd_c3_readoff",  32'(MemRead), 32'd0);
    @(negedge clk);
    chk("rd_rsp_taken", 32'(rsp_valid), 32'd0);

    // Read stalled in RESP while four writes fill the FIFO
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0010;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_rspvalid", 32'(rsp_valid), 32'd1);
    chk("bp_rdata",    rsp_rdata, 32'hE5A5_0010);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_ready_before_%0d", i), 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 32'h4000_0020 + 32'(4 * i); cmd_wdata = 32'h100 + 32'(i);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("bp_full",       32'(cmd_ready), 32'd0);
    chk("bp_nowrite",    32'(MemWrite), 32'd0);
    chk("bp_rsp_held",   32'(rsp_valid), 32'd1);
    chk("bp_rdata_held", rsp_rdata, 32'hE5A5_0010);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_clear",  32'(rsp_valid), 32'd0);
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_w%0d_strobe", i), 32'(MemWrite), 32'd1);
      chk($sformatf("bp_w%0d_addr", i),   Address, 32'h4000_0020 + 32'(4 * i));
      chk($sformatf("bp_w%0d_data", i),   WriteData, 32'h100 + 32'(i));
      chk($sformatf("bp_w%0d_ready", i),  32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("bp_w%0d_gap", i),    32'(MemWrite), 32'd0);
    end
    chk("bp_no_rsp", 32'(rsp_valid), 32'd0);

    // IRQ edge, clear, level held high, set-beats-clear
    IRQ = 1'b1;
    @(negedge clk);
    chk("irq_sync_delay", 32'(irq_pending), 32'd0);
    @(negedge clk);
    chk("irq_set",       32'(irq_pending), 32'd1);
    chk("irq_no_bus_rd", 32'(MemRead), 32'd0);
    chk("irq_no_bus_wr", 32'(MemWrite), 32'd0);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    chk("irq_cleared", 32'(irq_pending), 32'd0);
    repeat (3) @(negedge clk);
    chk("irq_level_no_reset", 32'(irq_pending), 32'd0);
    chk("irq_no_bus_any",     32'(MemRead | MemWrite), 32'd0);
    IRQ = 1'b0;
    repeat (2) @(negedge clk);
    IRQ = 1'b1; irq_clear = 1'b1;
    @(negedge clk);
    chk("irq_coinc_pre", 32'(irq_pending), 32'd0);
    @(negedge clk);
    chk("irq_set_wins",  32'(irq_pending), 32'd1);
    @(negedge clk);
    chk("irq_clear_after", 32'(irq_pending), 32'd0);
    irq_clear = 1'b0; IRQ = 1'b0;

    // Reset during ISSUE of a read with a second read queued
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0018;
    @(negedge clk);
    cmd_addr = 32'h4000_001C;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_issue_read", 32'(MemRead), 32'd1);
    chk("mid_issue_addr", Address, 32'h4000_0018);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read",  32'(MemRead), 32'd0);
    chk("mid_rst_rsp",   32'(rsp_valid), 32'd0);
    chk("mid_rst_addr",  Address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_fifo_empty_%0d", i), 32'(MemRead | MemWrite | rsp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Bus initiator for the memory-mapped peripheral bus (MemRead/MemWrite/Address/WriteData/ReadData, 0x4000_0000 region).
- Buffers host commands in a small FIFO and issues each one as a single-cycle bus access.
- Returns read data over a valid/ready response channel.
- Captures the peripheral IRQ line; sits between a test/debug host (or DMA-style sequencer) and the peripheral block.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TCON_ADDR, 32'h40000008, timer control register address, used by the optional IRQ auto-acknowledge.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  target address
- cmd_wdata  in  32  write data; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  32  read data
- MemRead  out  1  bus read strobe
- MemWrite  out  1  bus write strobe
- Address  out  32  bus address
- WriteData  out  32  bus write data
- ReadData  in  32  combinational read data from peripheral
- IRQ  in  1  peripheral interrupt level
- irq_pending  out  1  sticky flag set on IRQ rising edge
- irq_clear  in  1  clears irq_pending

Behaviour:
- Reset (async, rst_n low): all outputs 0, FIFO empty, state IDLE, IRQ edge register 0.
- Reset mid-operation aborts everything; queued commands are lost.
- FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = (count != DEPTH).
  - Pop only in IDLE.
  - Simultaneous push and pop when full is not allowed, since cmd_ready = 0.
  - Simultaneous push and pop when at least one entry exists: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO not empty, pop into bus registers, go to ISSUE.
  - ISSUE: exactly one cycle with MemRead or MemWrite = 1 and Address/WriteData stable (registered outputs).
    - Write: go to IDLE.
    - Read: capture ReadData at end of cycle into rsp_rdata, set rsp_valid, go to RESP.
  - RESP: hold rsp_valid and rsp_rdata until rsp_ready; then clear rsp_valid and go to IDLE.
- Outside ISSUE: MemRead = MemWrite = 0, WriteData = 0; Address holds its last value.
- Throughput:
  - Write: 2 cycles per command (IDLE, ISSUE).
  - Read: at least 3 cycles.
  - Read latency, command accepted to rsp_valid: 3 cycles with an empty FIFO.
- Writes produce no response. Commands complete strictly in order.
- IRQ: registered once. irq_pending is set on a 0→1 transition of the registered IRQ. irq_clear clears it; if set and clear coincide, set wins. A level held high does not re-set after a clear.

Optional Feature:
- Macro IRQ_AUTO_ACK_EN.
- With the macro defined, extra states ACK_RD, ACK_WAIT, ACK_WR are added.
  - Entry: from IDLE, an IRQ rising edge takes priority over the FIFO.
  - ACK_RD: read TCON_ADDR for one cycle and latch the value.
  - ACK_WAIT: one idle cycle.
  - ACK_WR: write latched & 32'hFFFFFFFB (clears interrupt status bit 2, keeps enable bits); then go to IDLE.
  - The ack read produces no rsp_valid; irq_pending is still set.
  - An edge arriving while a command is in flight is serviced at the next IDLE.
- Without the macro: no bus traffic is generated autonomously; IRQ only sets irq_pending.

Test Plan:
- Write 0x4000000C data 0x000000A5 → one cycle MemWrite = 1, Address = 0x4000000C, WriteData = 0xA5; no rsp_valid; peripheral led = 0xA5.
- Read 0x40000014 with rsp_ready = 1 → MemRead pulse of 1 cycle; rsp_valid 3 cycles after accept; rsp_rdata equals the systick value sampled during the ISSUE cycle.
- Push 4 writes back-to-back with DEPTH = 4 while a read sits in RESP with rsp_ready = 0 → cmd_ready drops after the 4th; release rsp_ready → the 4 writes issue in order, 2 cycles apart.
- Configure TH = 0xFFFFFFFE, TL = 0xFFFFFFFE, TCON = 3 → IRQ rises; irq_pending = 1 one cycle after registered edge. Assert irq_clear and irq_pending clears.
- With IRQ_AUTO_ACK_EN: same timer setup → bus shows read of 0x40000008 returning 7, then write of 3; IRQ deasserts; no rsp_valid generated.
- Assert rst_n = 0 during ISSUE of a read → MemRead and rsp_valid drop immediately; cmd_ready = 1 after release; FIFO empty.
